// File: rtl/ysyx_22050019_divider_cycle_if.sv
// Request/result bundle between the EX stage and the multi-cycle divider.
// The divider is the slave; the pipeline (or a testbench) is the master.
interface ysyx_22050019_divider_cycle_if #(
  parameter int XLEN = 64
);
  logic            div_valid;
  logic [2:0]      div_type;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush;
  logic            result_ready;
  logic [XLEN-1:0] div_out;
  logic            div_stall;
  logic            result_ok;

  modport master (
    output div_valid, div_type, dividend_i, divisor_i, flush, result_ready,
    input  div_out, div_stall, result_ok
  );

  modport slave (
    input  div_valid, div_type, dividend_i, divisor_i, flush, result_ready,
    output div_out, div_stall, result_ok
  );
endinterface

// File: rtl/ysyx_22050019_divider_cycle.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Magnitudes are divided one bit per cycle; signs are applied in a final FIX cycle.
module ysyx_22050019_divider_cycle #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic rst_n,
  ysyx_22050019_divider_cycle_if.slave dif
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic              quoNeg_q, quoNeg_d;
  logic              remNeg_q, remNeg_d;
  logic              isRem_q, isRem_d;
  logic              isWord_q, isWord_d;
  logic [XLEN-1:0]   divOut_q, divOut_d;

  logic              isRemIn, isWordIn, isUnsIn;
  logic [XLEN-1:0]   dvdExt, dsrExt, magA, magB, quoInit, specialRes;
  logic              signA, signB, divZero, overflow;
  logic [XLEN:0]     shifted;
  logic              fits;
  logic [XLEN-1:0]   remStep, quoStep;
  logic [XLEN-1:0]   quoFix, remFix, fixRes;

  assign isRemIn  = dif.div_type[2];
  assign isWordIn = dif.div_type[1];
  assign isUnsIn  = dif.div_type[0];

  // Operand conditioning at accept: extend word operands, then take magnitudes.
  // The most-negative value's magnitude 2^(XLEN-1) is still exact as unsigned XLEN bits.
  always_comb begin
    dvdExt = dif.dividend_i;
    dsrExt = dif.divisor_i;
    if (isWordIn) begin
      dvdExt = isUnsIn ? {{(XLEN-32){1'b0}}, dif.dividend_i[31:0]} : sext32(dif.dividend_i);
      dsrExt = isUnsIn ? {{(XLEN-32){1'b0}}, dif.divisor_i[31:0]}  : sext32(dif.divisor_i);
    end
    signA    = ~isUnsIn & dvdExt[XLEN-1];
    signB    = ~isUnsIn & dsrExt[XLEN-1];
    magA     = signA ? -dvdExt : dvdExt;
    magB     = signB ? -dsrExt : dsrExt;
    quoInit  = isWordIn ? {magA[31:0], {(XLEN-32){1'b0}}} : magA;
    divZero  = (dsrExt == '0);
    overflow = ~isUnsIn & (isWordIn
               ? (dif.dividend_i[31:0] == 32'h8000_0000 && dif.divisor_i[31:0] == 32'hFFFF_FFFF)
               : (dif.dividend_i == MIN_NEG && dif.divisor_i == ALL_ONES));
    if (divZero) begin
      specialRes = isRemIn ? dvdExt : ALL_ONES;
    end else begin
      specialRes = isRemIn ? '0 : dvdExt;
    end
    if (isWordIn) begin
      specialRes = sext32(specialRes);
    end
  end

  // One restoring step: the shifted partial remainder can reach XLEN+1 bits.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    fits    = (shifted >= {1'b0, dsr_q});
    remStep = fits ? (shifted[XLEN-1:0] - dsr_q) : shifted[XLEN-1:0];
    quoStep = {quo_q[XLEN-2:0], fits};
  end

  always_comb begin
    quoFix = quoNeg_q ? -quo_q : quo_q;
    remFix = remNeg_q ? -rem_q : rem_q;
    fixRes = isRem_q ? remFix : quoFix;
    if (isWord_q) begin
      fixRes = sext32(fixRes);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    quoNeg_d = quoNeg_q;
    remNeg_d = remNeg_q;
    isRem_d  = isRem_q;
    isWord_d = isWord_q;
    divOut_d = divOut_q;
    unique case (state_q)
      IDLE: begin
        if (dif.div_valid && !dif.flush) begin
          isRem_d  = isRemIn;
          isWord_d = isWordIn;
          quoNeg_d = signA ^ signB;
          remNeg_d = signA;
          dsr_d    = magB;
          rem_d    = '0;
          quo_d    = quoInit;
          cnt_d    = isWordIn ? CNT_W'(XLEN/2) : CNT_W'(XLEN);
          if (divZero || overflow) begin
            divOut_d = specialRes;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        rem_d = remStep;
        quo_d = quoStep;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        divOut_d = fixRes;
        state_d  = DONE;
      end
      DONE: begin
        if (dif.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush wins over both a new accept and the consumer taking the result.
    if (dif.flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      quoNeg_q <= 1'b0;
      remNeg_q <= 1'b0;
      isRem_q  <= 1'b0;
      isWord_q <= 1'b0;
      divOut_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      quoNeg_q <= quoNeg_d;
      remNeg_q <= remNeg_d;
      isRem_q  <= isRem_d;
      isWord_q <= isWord_d;
      divOut_q <= divOut_d;
    end
  end

  assign dif.div_out   = divOut_q;
  assign dif.result_ok = (state_q == DONE);
  assign dif.div_stall = ((state_q == IDLE) && dif.div_valid && !dif.flush)
                       || (state_q == CALC) || (state_q == FIX)
                       || ((state_q == DONE) && !dif.result_ready);

endmodule
